// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle logic/arith/shift/compare ops plus an iterative
// radix-2 multiply / restoring divide unit writing HI/LO with a start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (f)
      4'd0:    y = a & b;
      4'd1:    y = a | b;
      4'd2:    y = a + b;
      4'd3:    y = a ^ b;
      4'd4:    y = b << shamt;
      4'd5:    y = b >> shamt;
      4'd6:    y = a - b;
      4'd7:    y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd8:    y = b_s >>> shamt;
      4'd9:    y = ~(a | b);
      4'd10:   y = {{(WIDTH-1){1'b0}}, (a < b)};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

  logic [0:0]       state;
  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] a_q;

  logic             is_md;
  logic             sgn_op;
  logic             launch;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign busy   = (state == RUN);
  assign is_md  = (f >= 4'd11) && (f <= 4'd14);
  assign sgn_op = (f == 4'd11) || (f == 4'd13);
  assign launch = start && !busy && is_md;
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

  // One iteration: acc_hi/acc_lo hold {partial product, multiplier} when
  // multiplying and {partial remainder, dividend/quotient} when dividing.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Sign restoration and architectural special cases applied on the final step.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_q ? -step_lo : step_lo;
      res_hi = neg_r ? -step_hi : step_hi;
      if (div0) begin
        res_lo = '1;
        res_hi = a_q;
      end else if (ovf) begin
        res_lo = MIN;
        res_hi = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      a_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state  <= RUN;
            cnt    <= SHW'(WIDTH-1);
            is_div <= (f == 4'd13) || (f == 4'd14);
            neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn_op && a[WIDTH-1];
            div0   <= (b == '0);
            ovf    <= (f == 4'd13) && (a == MIN) && (b == '1);
            a_q    <= a;
            acc_hi <= '0;
            if ((f == 4'd13) || (f == 4'd14)) begin
              acc_lo <= a_mag;
              opnd   <= b_mag;
            end else begin
              acc_lo <= b_mag;
              opnd   <= a_mag;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the 32-bit datapath ALU for the pipelined MIPS core, sitting in the EX stage.
- Adds a wider single-cycle operation set: XOR, NOR, unsigned compare and shifts.
- Adds an iterative multiply/divide unit with HI/LO result registers and a start/busy/done handshake.
- The hazard unit stalls on `busy`. MFHI/MFLO read the `hi`/`lo` outputs directly.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 4 and even.
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `a` in WIDTH: operand A / dividend / multiplicand.
- `b` in WIDTH: operand B / divisor / multiplier.
- `f` in 4: operation select.
- `shamt` in SHW: shift amount.
- `start` in 1: launch request for a multiply/divide op.
- `y` out WIDTH: combinational single-cycle result.
- `zero` out 1: `y == 0`.
- `hi` out WIDTH: registered HI (product upper half / remainder).
- `lo` out WIDTH: registered LO (product lower half / quotient).
- `busy` out 1: multiply/divide in progress.
- `done` out 1: one-cycle pulse when `hi`/`lo` have just been written.

## Operation
- **Single-cycle `f` codes** (combinational, unaffected by `busy`):
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL (`b << shamt`), 5 SRL (`b >> shamt`), 6 SUB, 7 SLT (signed; `y` = 1 or 0), 8 SRA (`b >>> shamt`, sign-filled), 9 NOR, 10 SLTU (unsigned).
  - ADD/SUB wrap modulo 2^WIDTH; there is no overflow output.
- **Multi-cycle `f` codes:** 11 MULT, 12 MULTU, 13 DIV, 14 DIVU. For these and for 15, `y` = 0.
- **Launch:** on an edge with `start && !busy && f` in 11..14.
  - `a`, `b` and `f` are latched; later changes to them have no effect.
  - `start` under any other condition is ignored, with no state change.
- **States:** IDLE → RUN (WIDTH iterations, counter WIDTH-1 down to 0) → IDLE.
- **Multiply:** radix-2 shift-add on magnitudes.
  - Signed product is negated when the operand signs differ.
  - `{hi, lo}` = full 2·WIDTH-bit product.
- **Divide:** restoring, on magnitudes.
  - `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
- **Divide by zero** (`b` = 0): `lo` = all ones, `hi` = `a` (signed and unsigned).
- **Signed overflow** (DIV of MIN by -1): `lo` = MIN, `hi` = 0.
- **HI/LO writes:** `hi`/`lo` change only at operation completion or reset, and hold their values indefinitely otherwise.

## Timing
- **Reset** (an edge with `reset` = 1): `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, FSM = IDLE, counter = 0.
  - Reset during RUN aborts the operation; no partial result reaches `hi`/`lo`.
  - `reset` takes priority over `start` on the same edge.
- **Single-cycle ops:** `y` and `zero` are valid in the same cycle as the inputs, with zero latency.
- **Launch edge E0:** `busy` = 1 from E0.
- **Iteration edges E1..E(WIDTH):** at E(WIDTH) `hi`/`lo` are written, `done` = 1, and `busy` = 0.
  - Result latency is WIDTH cycles from `busy` rising.
- **`done`:** high for exactly one cycle, then 0.
- **Back-to-back ops:** `start` in the `done` cycle is accepted, since `busy` is already 0. `busy` then rises on the next edge with no idle gap.
- **Simultaneous start/busy:** `start` while `busy` = 1 is dropped. The requester must hold `start` until it observes `busy`.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-MULT → `hi` = `lo` = 0, `busy` = `done` = 0 on the next cycle; `hi`/`lo` stay 0 afterwards.
- **Single-cycle sweep** (WIDTH = 32):
  - ADD 0x7FFFFFFF + 1 → `y` = 0x80000000.
  - SUB 5 − 5 → `y` = 0, `zero` = 1.
  - SLT −1 < 1 → 1; SLTU 0xFFFFFFFF < 1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000; SRL same → 0x08000000.
  - NOR 0 → 0xFFFFFFFF.
- **MULT / MULTU with `a` = −3, `b` = 7:**
  - MULT → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
  - MULTU same operands → `hi` = 0x00000006, `lo` = 0xFFFFFFEB.
  - `done` exactly 32 cycles after `busy` rises.
- **DIV / DIVU:**
  - DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIVU 100 / 7 → `lo` = 14, `hi` = 2.
  - DIV 0x80000000 / −1 → `lo` = 0x80000000, `hi` = 0.
  - DIVU 9 / 0 → `lo` = 0xFFFFFFFF, `hi` = 9.
- **Handshake:**
  - `start` pulsed again while `busy` → ignored, result unchanged.
  - `a`/`b` changed mid-RUN → result still reflects latched operands.
  - `start` in the `done` cycle → second op runs with no gap.
- **Parameter:** WIDTH = 8, MULTU 0xFF × 0xFF → `hi` = 0xFE, `lo` = 0x01, `done` 8 cycles after `busy`.
